// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: load funct3 codes, opcodes shared with ID,
// and the result payload carried in the writeback register.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } wb_res_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction from an aligned memory word, with
// misalignment detection for halfword and word loads.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_c,
    output logic            ok_c,
    output logic            misalign_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Undefined funct3 codes leave ok_c low without flagging an error.
    always_comb begin
        data_c     = '0;
        ok_c       = 1'b0;
        misalign_c = 1'b0;
        case (funct3)
            LB: begin
                data_c = {{24{byte_sel[7]}}, byte_sel};
                ok_c   = 1'b1;
            end
            LBU: begin
                data_c = {24'd0, byte_sel};
                ok_c   = 1'b1;
            end
            LH, LHU: begin
                if (offset[0]) begin
                    misalign_c = 1'b1;
                end else begin
                    data_c = (funct3 == LH) ? {{16{half_sel[15]}}, half_sel}
                                            : {16'd0, half_sel};
                    ok_c   = 1'b1;
                end
            end
            LW: begin
                if (offset != 2'd0) begin
                    misalign_c = 1'b1;
                end else begin
                    data_c = rdata;
                    ok_c   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single result register between MEM and the register file,
// with forwarding, hold/flush handling and a retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_we,
    input  logic [4:0]          in_wa,
    input  logic                in_load_sel,
    input  logic [2:0]          in_funct3,
    input  logic [31:0]         in_alu_result,
    input  logic [31:0]         in_mem_rdata,
    input  logic                hold,
    input  logic                flush,
    output logic                rf_we,
    output logic [4:0]          rf_wa,
    output logic [31:0]         rf_wd,
    output logic                fwd_valid,
    output logic [4:0]          fwd_wa,
    output logic [31:0]         fwd_wd,
    output logic                misalign_err,
    output logic [RETIRE_W-1:0] retire_count
);

    logic        out_valid;
    wb_res_t     res_q;
    wb_res_t     res_d;
    logic [31:0] ld_data;
    logic        ld_ok;
    logic        ld_mis;
    logic        accept;
    logic        retire;

    load_align u_load_align (
        .funct3     (in_funct3),
        .offset     (in_alu_result[1:0]),
        .rdata      (in_mem_rdata),
        .data_c     (ld_data),
        .ok_c       (ld_ok),
        .misalign_c (ld_mis)
    );

    assign in_ready = !flush && (!out_valid || !hold);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && !hold && !flush;

    // x0 writes and failed loads still occupy the register but never write.
    always_comb begin
        res_d    = '0;
        res_d.wa = in_wa;
        res_d.wd = in_load_sel ? ld_data : in_alu_result;
        res_d.we = in_we && (in_wa != 5'd0) && (!in_load_sel || ld_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            res_q        <= '0;
            misalign_err <= 1'b0;
            retire_count <= '0;
        end else begin
            misalign_err <= accept && in_load_sel && ld_mis;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                res_q     <= res_d;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
            if (retire) begin
                retire_count <= retire_count + RETIRE_W'(1);
            end
        end
    end

    assign rf_we     = out_valid && res_q.we && !hold;
    assign rf_wa     = res_q.wa;
    assign rf_wd     = res_q.wd;
    assign fwd_valid = out_valid && res_q.we;
    assign fwd_wa    = res_q.wa;
    assign fwd_wd    = res_q.wd;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; counter width is narrowed so the wrap-around
// case can be reached in a few hundred cycles.
module tb_wb_stage;

    localparam int unsigned RW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_we;
    logic [4:0]    in_wa;
    logic          in_load_sel;
    logic [2:0]    in_funct3;
    logic [31:0]   in_alu_result;
    logic [31:0]   in_mem_rdata;
    logic          hold;
    logic          flush;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic          fwd_valid;
    logic [4:0]    fwd_wa;
    logic [31:0]   fwd_wd;
    logic          misalign_err;
    logic [RW-1:0] retire_count;

    int checks   = 0;
    int failures = 0;

    wb_stage #(.RETIRE_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_we         (in_we),
        .in_wa         (in_wa),
        .in_load_sel   (in_load_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .hold          (hold),
        .flush         (flush),
        .rf_we         (rf_we),
        .rf_wa         (rf_wa),
        .rf_wd         (rf_wd),
        .fwd_valid     (fwd_valid),
        .fwd_wa        (fwd_wa),
        .fwd_wd        (fwd_wd),
        .misalign_err  (misalign_err),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] wa, input logic ls,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rd);
        in_valid      = v;
        in_we         = we;
        in_wa         = wa;
        in_load_sel   = ls;
        in_funct3     = f3;
        in_alu_result = alu;
        in_mem_rdata  = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        #3;
        chk("reset_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("reset_rf_we", 32'(rf_we), 32'h0);
        chk("reset_rf_wd", rf_wd, 32'h0);
        chk("reset_retire", 32'(retire_count), 32'h0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // LB sign-extends byte 3
        drive(1'b1, 1'b1, 5'd5, 1'b1, 3'b000, 32'h0000_1003, 32'h8011_2233);
        #1 chk("lb_in_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        chk("lb_rf_we", 32'(rf_we), 32'h1);
        chk("lb_rf_wa", 32'(rf_wa), 32'd5);
        chk("lb_rf_wd", rf_wd, 32'hFFFF_FF80);
        chk("lb_misalign", 32'(misalign_err), 32'h0);
        chk("lb_retire_pre", 32'(retire_count), 32'd0);
        tick();
        chk("lb_retire", 32'(retire_count), 32'd1);
        chk("lb_rf_we_after", 32'(rf_we), 32'h0);

        // LHU upper half, then misaligned LW back-to-back
        drive(1'b1, 1'b1, 5'd6, 1'b1, 3'b101, 32'h0000_2002, 32'hBEEF_1234);
        tick();
        drive(1'b1, 1'b1, 5'd8, 1'b1, 3'b010, 32'h0000_2001, 32'hBEEF_1234);
        chk("lhu_rf_we", 32'(rf_we), 32'h1);
        chk("lhu_rf_wa", 32'(rf_wa), 32'd6);
        chk("lhu_rf_wd", rf_wd, 32'h0000_BEEF);
        tick();
        idle();
        chk("lw_mis_rf_we", 32'(rf_we), 32'h0);
        chk("lw_mis_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("lw_mis_err", 32'(misalign_err), 32'h1);
        chk("lw_mis_retire_pre", 32'(retire_count), 32'd2);
        tick();
        chk("lw_mis_err_pulse_end", 32'(misalign_err), 32'h0);
        chk("lw_mis_retire", 32'(retire_count), 32'd3);

        // LH sign-extend, ALU to x0, undefined funct3
        drive(1'b1, 1'b1, 5'd9, 1'b1, 3'b001, 32'h0000_0010, 32'h0000_8001);
        tick();
        drive(1'b1, 1'b1, 5'd0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0);
        chk("lh_rf_wd", rf_wd, 32'hFFFF_8001);
        chk("lh_rf_we", 32'(rf_we), 32'h1);
        tick();
        drive(1'b1, 1'b1, 5'd4, 1'b1, 3'b011, 32'h0000_0000, 32'h1111_2222);
        chk("x0_rf_we", 32'(rf_we), 32'h0);
        chk("x0_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("x0_retire_pre", 32'(retire_count), 32'd4);
        tick();
        idle();
        chk("undef_rf_we", 32'(rf_we), 32'h0);
        chk("undef_misalign", 32'(misalign_err), 32'h0);
        tick();
        chk("undef_retire", 32'(retire_count), 32'd6);

        // Hold for three cycles with the next instruction waiting
        drive(1'b1, 1'b1, 5'd7, 1'b0, 3'b000, 32'h0000_0007, 32'h0);
        tick();
        drive(1'b1, 1'b1, 5'd10, 1'b0, 3'b000, 32'h0000_0055, 32'h0);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rf_we", 32'(rf_we), 32'h0);
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            chk("hold_fwd_valid", 32'(fwd_valid), 32'h1);
            chk("hold_fwd_wd", fwd_wd, 32'h0000_0007);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("release_rf_we", 32'(rf_we), 32'h1);
        chk("release_rf_wd", rf_wd, 32'h0000_0007);
        chk("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        chk("next_rf_wa", 32'(rf_wa), 32'd10);
        chk("next_rf_wd", rf_wd, 32'h0000_0055);
        chk("hold_retire", 32'(retire_count), 32'd7);
        tick();
        chk("hold_retire2", 32'(retire_count), 32'd8);

        // Flush with hold and a waiting instruction: flush wins, nothing accepted
        drive(1'b1, 1'b1, 5'd11, 1'b0, 3'b000, 32'h0000_0099, 32'h0);
        tick();
        drive(1'b1, 1'b1, 5'd12, 1'b0, 3'b000, 32'h0000_00AA, 32'h0);
        hold  = 1'b1;
        flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        #1;
        chk("flush_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("flush_rf_we", 32'(rf_we), 32'h0);
        chk("flush_retire", 32'(retire_count), 32'd8);
        tick();
        chk("flush_retire2", 32'(retire_count), 32'd8);

        // Asynchronous reset while holding a result
        drive(1'b1, 1'b1, 5'd13, 1'b0, 3'b000, 32'h0000_0077, 32'h0);
        tick();
        idle();
        hold = 1'b1;
        #1 chk("pre_rst_fwd_valid", 32'(fwd_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("arst_fwd_wa", 32'(fwd_wa), 32'h0);
        chk("arst_fwd_wd", fwd_wd, 32'h0);
        chk("arst_rf_wa", 32'(rf_wa), 32'h0);
        chk("arst_retire", 32'(retire_count), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        drive(1'b1, 1'b1, 5'd14, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
        tick();
        idle();
        chk("first_accept_rf_we", 32'(rf_we), 32'h1);
        chk("first_accept_rf_wa", 32'(rf_wa), 32'd14);
        chk("first_accept_rf_wd", rf_wd, 32'h0000_1234);
        tick();
        chk("first_accept_retire", 32'(retire_count), 32'd1);

        // Stream retires up to the counter maximum, then wrap
        drive(1'b1, 1'b1, 5'd0, 1'b0, 3'b000, 32'h0000_0001, 32'h0);
        tick();
        repeat (254) tick();
        chk("retire_max", 32'(retire_count), 32'h0000_00FF);
        idle();
        tick();
        chk("retire_wrap", 32'(retire_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  MEM stage presents an instruction result.
REQ-005 in_ready  output  1  wb_stage accepts the result this cycle.
REQ-006 in_we  input  1  instruction writes a destination register.
REQ-007 in_wa  input  5  destination register index (instruction[11:7]).
REQ-008 in_load_sel  input  1  result comes from memory, not ALU.
REQ-009 in_funct3  input  3  load width/sign code.
REQ-010 in_alu_result  input  32  ALU result; for loads, the byte address.
REQ-011 in_mem_rdata  input  32  aligned 32-bit word read from data memory.
REQ-012 hold  input  1  register file cannot take a write this cycle.
REQ-013 flush  input  1  discard the instruction held in wb_stage.
REQ-014 rf_we  output  1  register file write enable.
REQ-015 rf_wa  output  5  register file write address.
REQ-016 rf_wd  output  32  register file write data.
REQ-017 fwd_valid  output  1  fwd_wa/fwd_wd carry a pending nonzero-register result for ID forwarding.
REQ-018 fwd_wa  output  5  forwarded register index.
REQ-019 fwd_wd  output  32  forwarded data.
REQ-020 misalign_err  output  1  one-cycle pulse, misaligned load accepted.
REQ-021 retire_count  output  RETIRE_W  instructions retired since reset.

Function
REQ-022 One output register (valid, we, wa, wd); accept occurs when in_valid & in_ready at a rising edge.
REQ-023 in_ready = !out_valid | !hold (combinational); hold with empty register still accepts.
REQ-024 Latency: accepted at edge N -> rf_we/rf_wa/rf_wd valid in cycle after edge N.
REQ-025 rf_we = out_valid & out_we & !hold; rf_wa = out_wa; rf_wd = out_wd.
REQ-026 Register retires (valid cleared, or replaced by a simultaneous accept) at an edge where out_valid & !hold.
REQ-027 Write to in_wa = 0 captured with out_we = 0; never drives rf_we.
REQ-028 ALU path: wd = in_alu_result.
REQ-029 Load path, byte offset = in_alu_result[1:0]: funct3 000 LB sign-extend selected byte; 100 LBU zero-extend; 001 LH sign-extend halfword at offset[1]; 101 LHU zero-extend; 010 LW full word.
REQ-030 Misaligned: LH/LHU with offset[0]=1, LW with offset != 0 -> out_we = 0, misalign_err pulses the cycle after accept; instruction still retires.
REQ-031 Undefined load funct3 (011,110,111) -> out_we = 0, no error pulse.
REQ-032 fwd_valid = out_valid & out_we; fwd_wa/fwd_wd = out_wa/out_wd, asserted regardless of hold.
REQ-033 retire_count increments by 1 at each retiring edge (REQ-026); wraps modulo 2^RETIRE_W.
REQ-034 flush: at that edge out_valid <- 0, no accept (in_ready forced 0 while flush=1), no retire count, no error pulse.
REQ-035 hold and flush same cycle: flush wins.

Reset
REQ-036 rst_n low: out_valid, rf_we, fwd_valid, misalign_err = 0; rf_wa, rf_wd, fwd_wa, fwd_wd = 0; retire_count = 0; immediately, independent of clk.
REQ-037 Reset mid-hold discards the held result; no write after release.
REQ-038 First accept possible at first rising edge after rst_n deasserts.

Structure
REQ-039 Shared package wb_pkg: load funct3 constants (LB, LH, LW, LBU, LHU) and opcode constants shared with the ID stage.
REQ-040 One sub-module load_align: combinational byte/halfword extraction and misalign detection; state in wb_stage only.

Verification
REQ-041 LB, addr 0x1003, rdata 0x80112233, wa=5 -> next cycle rf_we=1, rf_wa=5, rf_wd=0xFFFFFF80, retire_count=1.
REQ-042 LHU, addr 0x2002, rdata 0xBEEF1234 -> rf_wd=0x0000BEEF; LW addr 0x2001 -> rf_we=0, misalign_err pulse 1 cycle, retire_count +1.
REQ-043 ALU result 0xDEADBEEF to wa=0 -> rf_we stays 0, fwd_valid=0, retire_count +1.
REQ-044 Result wa=7 held by hold=1 for 3 cycles -> rf_we=0, in_ready=0, fwd_valid=1 throughout; hold drop -> one write of 0x00000007 data, next instruction accepted same edge.
REQ-045 flush and hold together with pending result -> next cycle out_valid=0, no write, retire_count unchanged.
REQ-046 rst_n low mid-hold -> all outputs 0 asynchronously; retire_count preset to 0xFFFFFFFF via forced retires -> one more retire wraps to 0.
